router_fsm_np: RTL and testbench
================================

# router_fsm_np

Parametrised packet-router control FSM for a 1×NUM_PORTS router. It sits between the input register/parity block and NUM_PORTS output FIFOs and sequences header decode, payload load, FIFO-full stall and parity check. New over the 1×3 controller: port count and address width are generic, a destination is latched per packet, illegal addresses are dropped, and a bounded wait-till-empty timeout is added.

## Interface
Parameters:
- NUM_PORTS, 3, number of destination FIFOs (2..16)
- ADDR_W, $clog2(NUM_PORTS), header address field width
- WAIT_TIMEOUT, 30, max cycles in WAIT_TILL_EMPTY before drop; 0 disables the timeout

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- pkt_valid  in  1  packet byte valid from source
- data_in  in  ADDR_W  header address field, sampled in DECODE_ADDRESS only
- fifo_full  in  1  full flag of the selected FIFO (muxed externally by dest_sel)
- fifo_empty  in  NUM_PORTS  per-FIFO empty flags
- soft_reset  in  NUM_PORTS  per-FIFO read-timeout soft resets
- parity_done  in  1  parity byte captured
- low_packet_valid  in  1  pkt_valid fell while in FIFO_FULL_STATE
- detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg, write_enb_reg, busy  out  1 each  state decodes
- drop_state  out  1  packet being discarded
- dest_sel  out  NUM_PORTS  one-hot latched destination
- wait_timeout  out  1  single-cycle pulse on timeout drop

## Operation
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, WAIT_TILL_EMPTY, LOAD_PARITY, CHECK_PARITY_ERROR, FIFO_FULL_STATE, LOAD_AFTER_FULL, DROP_PACKET.
- DECODE_ADDRESS: no pkt_valid → stay. pkt_valid and data_in ≥ NUM_PORTS → DROP_PACKET. Otherwise latch dest = data_in; fifo_empty[data_in] → LOAD_FIRST_DATA, else WAIT_TILL_EMPTY.
- LOAD_FIRST_DATA → LOAD_DATA unconditionally.
- LOAD_DATA: fifo_full → FIFO_FULL_STATE; else !pkt_valid → LOAD_PARITY; else stay.
- WAIT_TILL_EMPTY: checks only fifo_empty[dest]; set → LOAD_FIRST_DATA. Wait counter is cleared on entry and increments each cycle spent here; when WAIT_TIMEOUT≠0 and counter = WAIT_TIMEOUT−1 with FIFO still non-empty → DROP_PACKET, wait_timeout pulses. Empty takes priority over timeout in the same cycle.
- LOAD_PARITY → CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full → FIFO_FULL_STATE, else DECODE_ADDRESS.
- FIFO_FULL_STATE: stay while fifo_full; else → LOAD_AFTER_FULL.
- LOAD_AFTER_FULL: parity_done → DECODE_ADDRESS; else low_packet_valid → LOAD_PARITY; else LOAD_DATA.
- DROP_PACKET: stay while pkt_valid; !pkt_valid → DECODE_ADDRESS. No writes.
- Soft reset: only soft_reset[dest] forces DECODE_ADDRESS, and only outside DECODE_ADDRESS/DROP_PACKET; soft_reset on other ports is ignored. Priority: reset > soft_reset[dest] > next state.
- Outputs (Moore, decoded from state only): detect_add=DECODE_ADDRESS; lfd_state=LOAD_FIRST_DATA; ld_state=LOAD_DATA; full_state=FIFO_FULL_STATE; laf_state=LOAD_AFTER_FULL; rst_int_reg=CHECK_PARITY_ERROR; drop_state=DROP_PACKET; write_enb_reg=LOAD_DATA|LOAD_PARITY|LOAD_AFTER_FULL; busy=1 in all states except DECODE_ADDRESS, LOAD_DATA, DROP_PACKET.
- dest_sel = one-hot(dest) in all states except DECODE_ADDRESS and DROP_PACKET, where it is 0.

## Timing
- Reset: state DECODE_ADDRESS, dest=0, wait counter=0. After reset detect_add=1, all other outputs 0, dest_sel=0.
- Header with pkt_valid at edge N → LOAD_FIRST_DATA (or WAIT_TILL_EMPTY/DROP_PACKET) visible after edge N; lfd_state high exactly one cycle.
- wait_timeout is registered, high for exactly the first cycle of DROP_PACKET.
- Reset mid-packet: DECODE_ADDRESS the following cycle, counter cleared, no wait_timeout.

## Structure
- Package router_pkg: state enum (4-bit), NUM_PORTS/ADDR_W defaults, onehot helper function.
- Sub-module router_wait_timer: clear/enable/terminal-count counter, width $clog2(WAIT_TIMEOUT+1); omitted when WAIT_TIMEOUT=0.

## Test plan
- NUM_PORTS=3, all empty, header addr 2, 4 payload bytes, pkt_valid drops → DA,LFD,LD×4,LP,CPE,DA; dest_sel=3'b100; write_enb_reg high 5 cycles.
- Header addr 3 with NUM_PORTS=3 → DROP_PACKET, busy=0, write_enb_reg=0 for whole packet, return to DA one cycle after pkt_valid low.
- fifo_empty[1]=0, addr 1, fifo_empty[0]=1 → stays WAIT_TILL_EMPTY; fifo_empty[1] set at cycle 5 → LFD next cycle, no timeout.
- WAIT_TIMEOUT=4, FIFO 0 never empties → DROP_PACKET after 4 WAIT cycles, wait_timeout 1-cycle pulse.
- fifo_full in LOAD_DATA for 3 cycles, then low_packet_valid=1 → FFS×3, LAF, LP, CPE; busy=1 throughout.
- In LOAD_DATA to port 0: soft_reset[2] ignored; soft_reset[0] → DA next cycle; reset asserted in FFS → DA, detect_add=1.

Source files
------------

// File: rtl/router_fsm_np_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared state encoding, default sizing and one-hot helper for
//               the 1xN packet-router control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int c_max_ports     = 16;
    localparam int c_def_num_ports = 3;
    localparam int c_def_addr_w    = $clog2(c_def_num_ports);

    typedef enum logic [3:0] {
        ST_DECODE_ADDRESS     = 4'd0,
        ST_LOAD_FIRST_DATA    = 4'd1,
        ST_LOAD_DATA          = 4'd2,
        ST_WAIT_TILL_EMPTY    = 4'd3,
        ST_LOAD_PARITY        = 4'd4,
        ST_CHECK_PARITY_ERROR = 4'd5,
        ST_FIFO_FULL_STATE    = 4'd6,
        ST_LOAD_AFTER_FULL    = 4'd7,
        ST_DROP_PACKET        = 4'd8
    } state_t;

    // Callers truncate the result to their own port count.
    function automatic logic [c_max_ports-1:0] onehot(input logic [3:0] idx);
        logic [c_max_ports-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_fsm_np_if.sv
`default_nettype none
// ============================================================================
// Module      : router_fsm_np_if
// Description : Control/status bundle between the router datapath, the output
//               FIFOs and the router control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
interface router_fsm_np_if #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = $clog2(NUM_PORTS)
);
    logic                  pkt_valid;
    logic [ADDR_W-1:0]     data_in;
    logic                  fifo_full;
    logic [NUM_PORTS-1:0]  fifo_empty;
    logic [NUM_PORTS-1:0]  soft_reset;
    logic                  parity_done;
    logic                  low_packet_valid;

    logic                  detect_add;
    logic                  lfd_state;
    logic                  ld_state;
    logic                  full_state;
    logic                  laf_state;
    logic                  rst_int_reg;
    logic                  write_enb_reg;
    logic                  busy;
    logic                  drop_state;
    logic [NUM_PORTS-1:0]  dest_sel;
    logic                  wait_timeout;

    // Environment side: drives packet/FIFO status, observes FSM decodes.
    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_packet_valid,
        input  detect_add, lfd_state, ld_state, full_state, laf_state,
               rst_int_reg, write_enb_reg, busy, drop_state, dest_sel,
               wait_timeout
    );

    // FSM side.
    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_packet_valid,
        output detect_add, lfd_state, ld_state, full_state, laf_state,
               rst_int_reg, write_enb_reg, busy, drop_state, dest_sel,
               wait_timeout
    );

endinterface
`default_nettype wire

// File: rtl/router_fsm_np_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : router_wait_timer
// Description : Clearable, saturating cycle counter that flags the last
//               permitted cycle of a bounded wait.
// Revision    : 1.0 - initial release
// ============================================================================
module router_wait_timer #(
    parameter int WAIT_TIMEOUT = 30
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_tc
);

    localparam int                 c_cnt_w = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WAIT_TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_count;

    // Saturate at the terminal value so a stalled consumer never wraps it.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_last)) begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

    assign o_tc = i_enable && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/router_fsm_np.sv
`default_nettype none
// ============================================================================
// Module      : router_fsm_np
// Description : 1xNUM_PORTS packet-router control FSM: header decode with
//               per-packet destination latch, illegal-address drop, FIFO-full
//               stall, parity sequencing and bounded wait-till-empty.
// Revision    : 1.0 - initial release
// ============================================================================
module router_fsm_np
    import router_pkg::*;
#(
    parameter int NUM_PORTS    = c_def_num_ports,
    parameter int ADDR_W       = $clog2(NUM_PORTS),
    parameter int WAIT_TIMEOUT = 30
) (
    input  wire logic        clock,
    input  wire logic        reset,
    router_fsm_np_if.slave   bus
);

    state_t               r_state;
    state_t               w_state_next;
    logic [ADDR_W-1:0]    r_dest;
    logic [ADDR_W-1:0]    w_dest_next;
    logic                 r_wait_timeout;
    logic                 w_timeout_fire;

    logic [NUM_PORTS-1:0] w_hdr_onehot;
    logic [NUM_PORTS-1:0] w_dest_onehot;
    logic                 w_hdr_illegal;
    logic                 w_hdr_empty;
    logic                 w_dest_empty;
    logic                 w_soft_hit;
    logic                 w_in_wait;
    logic                 w_timer_tc;
    logic                 w_idle_like;

    // One-hot masks avoid out-of-range bit selects when ADDR_W can encode
    // more values than there are ports.
    assign w_hdr_onehot  = NUM_PORTS'(onehot(4'(bus.data_in)));
    assign w_dest_onehot = NUM_PORTS'(onehot(4'(r_dest)));
    assign w_hdr_illegal = ({1'b0, bus.data_in} >= (ADDR_W + 1)'(NUM_PORTS));
    assign w_hdr_empty   = |(bus.fifo_empty & w_hdr_onehot);
    assign w_dest_empty  = |(bus.fifo_empty & w_dest_onehot);
    assign w_soft_hit    = |(bus.soft_reset & w_dest_onehot);
    assign w_in_wait     = (r_state == ST_WAIT_TILL_EMPTY);
    assign w_idle_like   = (r_state == ST_DECODE_ADDRESS) ||
                           (r_state == ST_DROP_PACKET);

    generate
        if (WAIT_TIMEOUT > 0) begin : g_wait_timer
            router_wait_timer #(
                .WAIT_TIMEOUT (WAIT_TIMEOUT)
            ) u_wait_timer (
                .clk      (clock),
                .rst      (reset),
                .i_clear  (!w_in_wait),
                .i_enable (w_in_wait),
                .o_tc     (w_timer_tc)
            );
        end else begin : g_no_wait_timer
            assign w_timer_tc = 1'b0;
        end
    endgenerate

    always_comb begin
        w_state_next   = r_state;
        w_dest_next    = r_dest;
        w_timeout_fire = 1'b0;

        case (r_state)
            ST_DECODE_ADDRESS: begin
                if (bus.pkt_valid) begin
                    if (w_hdr_illegal) begin
                        w_state_next = ST_DROP_PACKET;
                    end else begin
                        w_dest_next  = bus.data_in;
                        w_state_next = w_hdr_empty ? ST_LOAD_FIRST_DATA
                                                   : ST_WAIT_TILL_EMPTY;
                    end
                end
            end
            ST_LOAD_FIRST_DATA: w_state_next = ST_LOAD_DATA;
            ST_LOAD_DATA: begin
                if (bus.fifo_full) begin
                    w_state_next = ST_FIFO_FULL_STATE;
                end else if (!bus.pkt_valid) begin
                    w_state_next = ST_LOAD_PARITY;
                end
            end
            ST_WAIT_TILL_EMPTY: begin
                // Emptying on the terminal cycle still lets the packet through.
                if (w_dest_empty) begin
                    w_state_next = ST_LOAD_FIRST_DATA;
                end else if (w_timer_tc) begin
                    w_state_next   = ST_DROP_PACKET;
                    w_timeout_fire = 1'b1;
                end
            end
            ST_LOAD_PARITY: w_state_next = ST_CHECK_PARITY_ERROR;
            ST_CHECK_PARITY_ERROR: begin
                w_state_next = bus.fifo_full ? ST_FIFO_FULL_STATE
                                             : ST_DECODE_ADDRESS;
            end
            ST_FIFO_FULL_STATE: begin
                if (!bus.fifo_full) begin
                    w_state_next = ST_LOAD_AFTER_FULL;
                end
            end
            ST_LOAD_AFTER_FULL: begin
                if (bus.parity_done) begin
                    w_state_next = ST_DECODE_ADDRESS;
                end else if (bus.low_packet_valid) begin
                    w_state_next = ST_LOAD_PARITY;
                end else begin
                    w_state_next = ST_LOAD_DATA;
                end
            end
            ST_DROP_PACKET: begin
                if (!bus.pkt_valid) begin
                    w_state_next = ST_DECODE_ADDRESS;
                end
            end
            default: w_state_next = ST_DECODE_ADDRESS;
        endcase

        // A read-timeout on the active FIFO abandons the packet in flight.
        if (!w_idle_like && w_soft_hit) begin
            w_state_next   = ST_DECODE_ADDRESS;
            w_timeout_fire = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_DECODE_ADDRESS;
            r_dest         <= '0;
            r_wait_timeout <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_dest         <= w_dest_next;
            r_wait_timeout <= w_timeout_fire;
        end
    end

    assign bus.detect_add    = (r_state == ST_DECODE_ADDRESS);
    assign bus.lfd_state     = (r_state == ST_LOAD_FIRST_DATA);
    assign bus.ld_state      = (r_state == ST_LOAD_DATA);
    assign bus.full_state    = (r_state == ST_FIFO_FULL_STATE);
    assign bus.laf_state     = (r_state == ST_LOAD_AFTER_FULL);
    assign bus.rst_int_reg   = (r_state == ST_CHECK_PARITY_ERROR);
    assign bus.drop_state    = (r_state == ST_DROP_PACKET);
    assign bus.write_enb_reg = (r_state == ST_LOAD_DATA)   ||
                               (r_state == ST_LOAD_PARITY) ||
                               (r_state == ST_LOAD_AFTER_FULL);
    assign bus.busy          = !((r_state == ST_DECODE_ADDRESS) ||
                                 (r_state == ST_LOAD_DATA)      ||
                                 (r_state == ST_DROP_PACKET));
    assign bus.dest_sel      = w_idle_like ? '0 : w_dest_onehot;
    assign bus.wait_timeout  = r_wait_timeout;

endmodule
`default_nettype wire

// File: tb/tb_router_fsm_np.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_fsm_np
// Description : Randomised scoreboard bench for router_fsm_np with a
//               packet-level behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_fsm_np;

    localparam int c_np       = 3;
    localparam int c_aw       = 2;
    localparam int c_wt       = 4;
    localparam int c_n_cycles = 6000;

    typedef enum int {
        M_DA, M_LFD, M_LD, M_WTE, M_LP, M_CPE, M_FFS, M_LAF, M_DROP
    } m_state_e;

    typedef struct {
        logic [12:0] vec;
        int          cyc;
    } exp_t;

    logic clock;
    logic reset;

    router_fsm_np_if #(.NUM_PORTS(c_np), .ADDR_W(c_aw)) bus ();

    router_fsm_np #(
        .NUM_PORTS    (c_np),
        .ADDR_W       (c_aw),
        .WAIT_TIMEOUT (c_wt)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Expected outputs: {detect_add, lfd, ld, full, laf, rst_int, write_enb,
    //                    busy, drop, wait_timeout, dest_sel[2:0]}
    function automatic logic [12:0] expect_vec(m_state_e s, int dest, bit to);
        logic [2:0] sel;
        bit         we;
        bit         bz;
        sel = (s == M_DA || s == M_DROP) ? 3'b000 : 3'(1 << dest);
        we  = (s == M_LD) || (s == M_LP) || (s == M_LAF);
        bz  = !((s == M_DA) || (s == M_LD) || (s == M_DROP));
        return {s == M_DA, s == M_LFD, s == M_LD, s == M_FFS, s == M_LAF,
                s == M_CPE, we, bz, s == M_DROP, to, sel};
    endfunction

    // Monitor: one expected entry is queued per clock edge after stimulus starts.
    initial begin
        exp_t        e;
        logic [12:0] act;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {bus.detect_add, bus.lfd_state, bus.ld_state,
                       bus.full_state, bus.laf_state, bus.rst_int_reg,
                       bus.write_enb_reg, bus.busy, bus.drop_state,
                       bus.wait_timeout, bus.dest_sel};
                n_checks++;
                if (act !== e.vec) begin
                    n_errors++;
                    $display("FAIL outputs cycle %0d: got %b required %b",
                             e.cyc, act, e.vec);
                end
            end
        end
    end

    initial begin
        m_state_e   m_st;
        m_state_e   nxt;
        int         m_dest;
        int         nd;
        int         m_waited;
        bit         m_to;
        bit         to;
        bit         rs, pv, ff, pd, lpv;
        int         din;
        logic [2:0] em, sr;
        int         pe, pf, phase;
        exp_t       e;

        m_st     = M_DA;
        m_dest   = 0;
        m_waited = 0;
        m_to     = 0;

        reset                = 1'b1;
        bus.pkt_valid        = 1'b0;
        bus.data_in          = '0;
        bus.fifo_full        = 1'b0;
        bus.fifo_empty       = '1;
        bus.soft_reset       = '0;
        bus.parity_done      = 1'b0;
        bus.low_packet_valid = 1'b0;

        for (int i = 0; i < c_n_cycles; i++) begin
            @(negedge clock);
            phase = i / (c_n_cycles / 4);
            case (phase)
                0:       begin pe = 90; pf = 15; end
                1:       begin pe = 30; pf = 15; end
                2:       begin pe = 10; pf = 15; end
                default: begin pe = 50; pf = 40; end
            endcase

            rs  = (i < 3) || ($urandom_range(0, 199) == 0);
            pv  = ($urandom_range(0, 99) < 75);
            din = $urandom_range(0, 3);
            ff  = ($urandom_range(0, 99) < pf);
            pd  = ($urandom_range(0, 99) < 20);
            lpv = ($urandom_range(0, 99) < 20);
            for (int b = 0; b < c_np; b++) begin
                em[b] = ($urandom_range(0, 99) < pe);
                sr[b] = ($urandom_range(0, 99) < 3);
            end

            reset                = rs;
            bus.pkt_valid        = pv;
            bus.data_in          = 2'(din);
            bus.fifo_full        = ff;
            bus.fifo_empty       = em;
            bus.soft_reset       = sr;
            bus.parity_done      = pd;
            bus.low_packet_valid = lpv;

            // Reference: what the controller should show after the next edge.
            if (rs) begin
                m_st     = M_DA;
                m_dest   = 0;
                m_waited = 0;
                m_to     = 0;
            end else begin
                nxt = m_st;
                nd  = m_dest;
                to  = 0;
                case (m_st)
                    M_DA: if (pv) begin
                        if (din >= c_np) nxt = M_DROP;
                        else begin
                            nd  = din;
                            nxt = em[din] ? M_LFD : M_WTE;
                        end
                    end
                    M_LFD:  nxt = M_LD;
                    M_LD:   nxt = ff ? M_FFS : (!pv ? M_LP : M_LD);
                    M_WTE: begin
                        if (em[m_dest]) nxt = M_LFD;
                        else if (c_wt != 0 && m_waited + 1 >= c_wt) begin
                            nxt = M_DROP;
                            to  = 1;
                        end
                    end
                    M_LP:   nxt = M_CPE;
                    M_CPE:  nxt = ff ? M_FFS : M_DA;
                    M_FFS:  nxt = ff ? M_FFS : M_LAF;
                    M_LAF:  nxt = pd ? M_DA : (lpv ? M_LP : M_LD);
                    M_DROP: nxt = pv ? M_DROP : M_DA;
                    default: nxt = M_DA;
                endcase
                if (m_st != M_DA && m_st != M_DROP && sr[m_dest]) begin
                    nxt = M_DA;
                    to  = 0;
                end
                m_waited = (m_st == M_WTE && nxt == M_WTE) ? m_waited + 1 : 0;
                m_st     = nxt;
                m_dest   = nd;
                m_to     = to;
            end

            e.vec = expect_vec(m_st, m_dest, m_to);
            e.cyc = i;
            exp_q.push_back(e);
        end

        @(posedge clock);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
